// File: rtl/keypad_pkg.sv
// Shared types and defaults for the 4x4 keypad scanner: FSM states, frame classes, code width.
package keypad_pkg;

    localparam int CODE_W            = 4;
    localparam int DEF_SCAN_TIME     = 5000;
    localparam int DEF_DEBOUNCE_CNT  = 4;
    localparam int DEF_REPEAT_DELAY  = 100;
    localparam int DEF_REPEAT_PERIOD = 25;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_SINGLE = 2'd1,
        FC_MULTI  = 2'd2
    } frame_class_t;

    typedef struct packed {
        frame_class_t        fclass;
        logic [CODE_W-1:0]   code;
    } frame_info_t;

    // Image bit row*4+col is 1 when that key reads closed; code is the lowest closed key.
    function automatic frame_info_t classify_frame(input logic [15:0] img);
        frame_info_t info;
        logic [4:0]  n;
        n         = 5'd0;
        info.code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (img[i]) begin
                n         = n + 5'd1;
                info.code = i[CODE_W-1:0];
            end
        end
        if (n == 5'd0)      info.fclass = FC_NONE;
        else if (n == 5'd1) info.fclass = FC_SINGLE;
        else                info.fclass = FC_MULTI;
        return info;
    endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row sequencer and frame capture: drives one row low per SCAN_TIME slot, samples columns in the slot's last cycle.
// frame/frame_done are valid together in the final cycle of row 3 (row 3 bits come straight from col_in).
// No backpressure: scanning free-runs from reset.
module keypad_row_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_TIME = DEF_SCAN_TIME
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] frame,
    output logic        frame_done
);

    localparam int            SW        = (SCAN_TIME > 1) ? $clog2(SCAN_TIME) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_TIME - 1);

    logic [SW-1:0] slot_cnt;
    logic [1:0]    row;
    logic [11:0]   image;
    logic          slot_last;

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign frame_done = slot_last && (row == 2'd3);
    // Columns are active-low; the image stores a closed key as 1.
    assign frame      = {~col_in, image};

    always_comb begin
        unique case (row)
            2'd0:    row_out = 4'b1110;
            2'd1:    row_out = 4'b1101;
            2'd2:    row_out = 4'b1011;
            default: row_out = 4'b0111;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            row      <= 2'd0;
            image    <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            row      <= row + 2'd1;
            unique case (row)
                2'd0:    image[3:0]  <= ~col_in;
                2'd1:    image[7:4]  <= ~col_in;
                2'd2:    image[11:8] <= ~col_in;
                default: ;
            endcase
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with frame debounce and valid/ready key output; auto-repeat when KEYPAD_REPEAT_EN is defined.
// Latency: key_valid rises one cycle after the last sample of the accepting frame.
// Backpressure: a key emitted while an unconsumed key is pending is dropped and key_overrun sticks high.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TIME     = DEF_SCAN_TIME,
    parameter int DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        col_in,
    output logic [3:0]        row_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              key_overrun
);

    if (SCAN_TIME < 1 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("keypad_scanner: all timing parameters must be at least 1");
    end

    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    logic [15:0]       frame;
    logic              frame_done;
    frame_info_t       info;
    kp_state_t         state;
    logic [CODE_W-1:0] cand;
    logic [DW-1:0]     dcnt;
    logic              dcnt_hit;
    logic              same_cand;
    logic              emit;
    logic [CODE_W-1:0] emit_code;

    keypad_row_scan #(
        .SCAN_TIME (SCAN_TIME)
    ) u_row_scan (
        .clk        (clk),
        .reset      (reset),
        .col_in     (col_in),
        .row_out    (row_out),
        .frame      (frame),
        .frame_done (frame_done)
    );

    assign info      = classify_frame(frame);
    assign same_cand = (info.fclass == FC_SINGLE) && (info.code == cand);
    // True when this frame brings the running count up to DEBOUNCE_CNT.
    assign dcnt_hit  = (int'(dcnt) + 1 >= DEBOUNCE_CNT);

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic          rep_armed;
    logic          rep_hit;

    assign rep_hit = (int'(rcnt) + 1 >= (rep_armed ? REPEAT_PERIOD : REPEAT_DELAY));
`endif

    always_comb begin
        emit      = 1'b0;
        emit_code = (state == ST_HELD) ? cand : info.code;
        if (frame_done) begin
            unique case (state)
                ST_IDLE:     emit = (info.fclass == FC_SINGLE) && (DEBOUNCE_CNT <= 1);
                ST_DEBOUNCE: emit = same_cand && dcnt_hit;
`ifdef KEYPAD_REPEAT_EN
                ST_HELD:     emit = (info.fclass != FC_NONE) && rep_hit;
`endif
                default:     emit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cand        <= '0;
            dcnt        <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_overrun <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt        <= '0;
            rep_armed   <= 1'b0;
`endif
        end else begin
            if (frame_done) begin
                unique case (state)
                    ST_IDLE: begin
                        if (info.fclass == FC_SINGLE) begin
                            cand <= info.code;
                            if (DEBOUNCE_CNT <= 1) begin
                                state    <= ST_HELD;
                                key_held <= 1'b1;
                                dcnt     <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rcnt      <= '0;
                                rep_armed <= 1'b0;
`endif
                            end else begin
                                state <= ST_DEBOUNCE;
                                dcnt  <= DW'(1);
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (!same_cand) begin
                            state <= ST_IDLE;
                            dcnt  <= '0;
                        end else if (dcnt_hit) begin
                            state    <= ST_HELD;
                            key_held <= 1'b1;
                            dcnt     <= '0;
`ifdef KEYPAD_REPEAT_EN
                            rcnt      <= '0;
                            rep_armed <= 1'b0;
`endif
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (info.fclass == FC_NONE) begin
                            if (DEBOUNCE_CNT <= 1) begin
                                state    <= ST_IDLE;
                                key_held <= 1'b0;
                                dcnt     <= '0;
                            end else begin
                                state <= ST_RELEASE;
                                dcnt  <= DW'(1);
                            end
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            if (rep_hit) begin
                                rcnt      <= '0;
                                rep_armed <= 1'b1;
                            end else begin
                                rcnt <= rcnt + RW'(1);
                            end
`endif
                        end
                    end
                    default: begin
                        // Release confirmation; any closed key returns to HELD with the repeat count frozen.
                        if (info.fclass != FC_NONE) begin
                            state <= ST_HELD;
                            dcnt  <= '0;
                        end else if (dcnt_hit) begin
                            state    <= ST_IDLE;
                            key_held <= 1'b0;
                            dcnt     <= '0;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                endcase
            end

            if (emit) begin
                if (key_valid && !key_ready) begin
                    key_overrun <= 1'b1;
                end else begin
                    key_code  <= emit_code;
                    key_valid <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus randomized key patterns checked against a frame-level model.
module tb_keypad_scanner;

    localparam int ST    = 4;
    localparam int DB    = 2;
    localparam int RD    = 3;
    localparam int RP    = 2;
    localparam int FRAME = 4 * ST;

    localparam int M_IDLE = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_held;
    logic        key_overrun;
    logic [15:0] pressed;

    int checks;
    int errors;

    // Reference model state
    int       cyc;
    int       m_state;
    int       m_cand;
    int       m_cnt;
    int       m_rc;
    bit       m_armed;
    bit       exp_valid;
    bit       exp_ovr;
    bit       exp_held;
    logic [3:0] exp_code;

    keypad_scanner #(
        .SCAN_TIME     (ST),
        .DEBOUNCE_CNT  (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .key_overrun (key_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad matrix: a driven-low row pulls down the columns of its closed keys.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row_out[r] == 1'b0) col_in = col_in & ~pressed[r*4 +: 4];
    end

    task automatic model_init();
        cyc = 0; m_state = M_IDLE; m_cand = 0; m_cnt = 0; m_rc = 0; m_armed = 0;
        exp_valid = 0; exp_ovr = 0; exp_held = 0; exp_code = 4'h0;
    endtask

    task automatic model_frame(output bit em, output logic [3:0] ec);
        int n;
        int code;
        n = $countones(pressed);
        code = 0;
        for (int i = 15; i >= 0; i--) if (pressed[i]) code = i;
        em = 0;
        ec = 4'(code);
        case (m_state)
            M_IDLE: if (n == 1) begin
                m_cand = code; m_cnt = 1;
                if (m_cnt >= DB) begin em = 1; m_state = M_HELD; m_rc = 0; m_armed = 0; end
                else m_state = M_DEB;
            end
            M_DEB: if (n == 1 && code == m_cand) begin
                m_cnt++;
                if (m_cnt >= DB) begin em = 1; m_state = M_HELD; m_rc = 0; m_armed = 0; end
            end else m_state = M_IDLE;
            M_HELD: if (n == 0) begin
                m_cnt = 1;
                m_state = (m_cnt >= DB) ? M_IDLE : M_REL;
            end else begin
`ifdef KEYPAD_REPEAT_EN
                m_rc++;
                if (m_rc == (m_armed ? RP : RD)) begin
                    em = 1; ec = 4'(m_cand); m_rc = 0; m_armed = 1;
                end
`endif
            end
            default: if (n == 0) begin
                m_cnt++;
                if (m_cnt >= DB) m_state = M_IDLE;
            end else m_state = M_HELD;
        endcase
        exp_held = (m_state == M_HELD || m_state == M_REL);
    endtask

    // One clock: advance the model with the inputs currently driven, then step to the next negedge.
    task automatic tick();
        bit em;
        logic [3:0] ec;
        em = 0;
        ec = 4'h0;
        if (cyc == FRAME - 1) model_frame(em, ec);
        if (em) begin
            if (exp_valid && !key_ready) exp_ovr = 1;
            else begin exp_code = ec; exp_valid = 1; end
        end else if (exp_valid && key_ready) exp_valid = 0;
        cyc = (cyc == FRAME - 1) ? 0 : cyc + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frames(input logic [15:0] keys, input int n, input logic rdy);
        pressed   = keys;
        key_ready = rdy;
        for (int i = 0; i < n * FRAME; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; key_ready = 0; pressed = 16'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_init();
    endtask

    task automatic test_reset();
        logic [3:0] er;
        reset = 1; key_ready = 0; pressed = 16'h0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (row_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 ||
            key_held !== 1'b0 || key_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: row=%b code=%h valid=%b held=%b ovr=%b, want row=1110 and all zero",
                     row_out, key_code, key_valid, key_held, key_overrun);
        end
        reset = 0;
        model_init();
        for (int k = 0; k < FRAME; k++) begin
            er = 4'b1111;
            er[k / ST] = 1'b0;
            checks++;
            if (row_out !== er) begin
                errors++;
                $display("FAIL row_scan cycle %0d: row_out=%b want %b", k, row_out, er);
            end
            tick();
        end
    endtask

    task automatic test_press();
        bit want;
        do_reset();
        pressed = 16'h0020;
        key_ready = 1;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            tick();
            // Frame 2 ends at cycle index 31; the key shows on the next cycle, the 33rd from frame 1 start.
            want = (k == 32);
            checks++;
            if (key_valid !== want) begin
                errors++;
                $display("FAIL press_valid cycle %0d: key_valid=%b want %b", k, key_valid, want);
            end
            if (k == 32) begin
                checks++;
                if (key_code !== 4'h5) begin
                    errors++;
                    $display("FAIL press_code: key_code=%h want 5", key_code);
                end
            end
        end
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL press_held: key_held=%b want 1", key_held);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        do_reset();
        key_ready = 1;
        seen = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            pressed = (k < FRAME) ? 16'h0400 : 16'h0;
            tick();
            if (key_valid || key_held) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL glitch_no_emit: valid/held seen=%b want 0", seen);
        end
        // From IDLE a fresh press must take two full frames, not one.
        run_frames(16'h0400, 1, 1'b1);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: key_valid=%b after one frame want 0", key_valid);
        end
        run_frames(16'h0400, 1, 1'b1);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'hA) begin
            errors++;
            $display("FAIL glitch_repress: valid=%b code=%h want 1/a", key_valid, key_code);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        run_frames(16'h0008, 2, 1'b0);
        run_frames(16'h0000, 2, 1'b0);
        run_frames(16'h1000, 2, 1'b0);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h3 || key_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drop: valid=%b code=%h ovr=%b want 1/3/1", key_valid, key_code, key_overrun);
        end
        key_ready = 1;
        tick();
        checks++;
        if (key_valid !== 1'b0 || key_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_consume: valid=%b ovr=%b want 0/1", key_valid, key_overrun);
        end
    endtask

    task automatic test_bounce();
        int emits;
        logic [15:0] seq_keys [7];
        seq_keys = '{16'h0080, 16'h0080, 16'h0000, 16'h0080, 16'h0080, 16'h0000, 16'h0000};
        do_reset();
        key_ready = 1;
        emits = 0;
        for (int f = 0; f < 7; f++) begin
            pressed = seq_keys[f];
            for (int k = 0; k < FRAME; k++) begin
                tick();
                if (key_valid) emits++;
            end
            if (f == 4) begin
                checks++;
                if (emits != 1) begin
                    errors++;
                    $display("FAIL bounce_one_emit: emits=%0d want 1", emits);
                end
            end
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release: key_held=%b want 0", key_held);
        end
        pressed = 16'h0080;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (key_valid) emits++;
        end
        checks++;
        if (emits != 2 || key_code !== 4'h7) begin
            errors++;
            $display("FAIL bounce_repress: emits=%0d code=%h want 2/7", emits, key_code);
        end
    endtask

    task automatic test_multi_reset();
        do_reset();
        run_frames(16'h0010, 2, 1'b0);
        run_frames(16'h0000, 2, 1'b0);
        run_frames(16'h0006, 3, 1'b0);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h4 || key_overrun !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL multi_no_emit: valid=%b code=%h ovr=%b held=%b want 1/4/0/0",
                     key_valid, key_code, key_overrun, key_held);
        end
        run_frames(16'h0000, 1, 1'b0);
        run_frames(16'h0100, 2, 1'b0);
        run_frames(16'h0100, 1, 1'b0);
        pressed = 16'h0020;
        for (int k = 0; k < FRAME + 5; k++) tick();
        #2 reset = 1;
        #1;
        checks++;
        if (row_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 ||
            key_held !== 1'b0 || key_overrun !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: row=%b code=%h valid=%b held=%b ovr=%b, want 1110 and zeros",
                     row_out, key_code, key_valid, key_held, key_overrun);
        end
        @(negedge clk);
        reset = 0;
        pressed = 16'h0;
        model_init();
        for (int k = 0; k <= ST; k++) begin
            checks++;
            if (row_out !== ((k < ST) ? 4'b1110 : 4'b1101)) begin
                errors++;
                $display("FAIL restart_slot cycle %0d: row_out=%b", k, row_out);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] one;
        int r, a, b, cur;
        one = 16'd1;
        cur = 0;
        do_reset();
        for (int f = 0; f < 60; f++) begin
            r = $urandom_range(0, 9);
            if (r == 6) pressed = 16'h0;
            else if (r == 7) begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                pressed = (one << a) | (one << b);
            end else if (r >= 8) begin
                cur = $urandom_range(0, 15);
                pressed = one << cur;
            end
            for (int k = 0; k < FRAME; k++) begin
                key_ready = ($urandom_range(0, 3) != 0);
                tick();
                checks++;
                if (key_valid !== exp_valid || key_code !== exp_code ||
                    key_held !== exp_held || key_overrun !== exp_ovr) begin
                    errors++;
                    $display("FAIL random f%0d c%0d: valid=%b code=%h held=%b ovr=%b want %b/%h/%b/%b",
                             f, k, key_valid, key_code, key_held, key_overrun,
                             exp_valid, exp_code, exp_held, exp_ovr);
                end
            end
        end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        bit want;
        do_reset();
        for (int f = 1; f <= 10; f++) begin
            run_frames(16'h8000, 1, 1'b1);
            want = (f == 2 || f == 5 || f == 7 || f == 9);
            checks++;
            if (key_valid !== want || (want && key_code !== 4'hF)) begin
                errors++;
                $display("FAIL repeat frame %0d: valid=%b code=%h want %b/f", f, key_valid, key_code, want);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1;
        key_ready = 0;
        pressed = 16'h0;
        model_init();
        test_reset();
        test_press();
        test_glitch();
        test_overrun();
        test_bounce();
        test_multi_reset();
        test_random();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_TIME, default 5000: clk cycles each row is driven.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive matching scan frames needed to accept a press or a release.
REQ-003 SHALL have parameter REPEAT_DELAY, default 100: held frames before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 25: frames between later auto-repeats.
REQ-005 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port col_in, input, 4: keypad columns, active-low, pulled up externally.
REQ-008 SHALL have port row_out, output, 4: keypad rows, active-low one-hot drive.
REQ-009 SHALL have port key_code, output, 4: accepted key = row*4 + col, 0x0..0xF, compatible with the 7-segment hex decode.
REQ-010 SHALL have port key_valid, output, 1: key_code holds an unconsumed key.
REQ-011 SHALL have port key_ready, input, 1: consumer accepts key_code on a clk edge where key_valid & key_ready.
REQ-012 SHALL have port key_held, output, 1: high in HELD and RELEASE states.
REQ-013 SHALL have port key_overrun, output, 1: sticky; a key event was dropped.

Function
REQ-014 SHALL drive row r (0..3) low for SCAN_TIME cycles, then move to row (r+1) mod 4; four rows form one frame of 4*SCAN_TIME cycles.
REQ-015 SHALL sample col_in in the last cycle of each row slot only, to allow settling.
REQ-016 SHALL classify each completed frame as NONE (no bit low), SINGLE(code) (exactly one of 16 low) or MULTI (two or more low).
REQ-017 SHALL use FSM states IDLE, DEBOUNCE, HELD, RELEASE, evaluated once per completed frame.
REQ-018 In IDLE: SINGLE(c) -> DEBOUNCE with candidate c, count=1; NONE or MULTI -> stay in IDLE.
REQ-019 In DEBOUNCE: SINGLE(same c) increments count; when count reaches DEBOUNCE_CNT, emit c and go to HELD; any other class -> IDLE. DEBOUNCE_CNT=1 emits on the first frame.
REQ-020 In HELD: NONE -> RELEASE, count=1; SINGLE or MULTI -> stay in HELD (rollover is ignored).
REQ-021 In RELEASE: NONE increments count; reaching DEBOUNCE_CNT -> IDLE; SINGLE or MULTI -> HELD.
REQ-022 On emit, SHALL assert key_valid and load key_code one cycle after the frame's last sample cycle.
REQ-023 SHALL hold key_valid and key_code stable until a clk edge with key_ready=1, then deassert key_valid the next cycle.
REQ-024 If an emit coincides with a handshake completion in the same cycle, SHALL load the new key and keep key_valid high.
REQ-025 If an emit occurs while key_valid=1 and key_ready=0, SHALL drop the new key, keep the old key_code and set key_overrun.
REQ-026 SHALL clear key_overrun only on reset.

Reset
REQ-027 While reset is high: row_out=4'b1110, key_code=0, key_valid=0, key_held=0, key_overrun=0, FSM=IDLE, all counters=0.
REQ-028 Reset mid-frame or mid-debounce SHALL discard the partial frame; scanning restarts at row 0 with a full SCAN_TIME slot.

Configuration
REQ-029 Macro KEYPAD_REPEAT_EN, when defined: in HELD, re-emit the held code after REPEAT_DELAY frames, then every REPEAT_PERIOD frames. Emits follow REQ-022..025. The repeat count restarts on each HELD entry and is frozen in RELEASE.
REQ-030 When KEYPAD_REPEAT_EN is undefined: exactly one emit per press, repeat counters not synthesized, REPEAT_* parameters ignored.

Structure
REQ-031 Package keypad_pkg SHALL hold FSM state encodings, frame class encodings, code width (4) and default parameter values.
REQ-032 Sub-module keypad_row_scan SHALL hold the row sequencer and frame capture, and output a 16-bit frame image plus a one-cycle frame_done strobe; the top level holds classification, FSM and handshake.

Verification (SCAN_TIME=4, DEBOUNCE_CNT=2, REPEAT_DELAY=3, REPEAT_PERIOD=2)
REQ-033 Press key 5 (row 1, col 1) for 3 frames, key_ready=1 -> one key_valid pulse, key_code=0x5, at cycle 33 after frame 1 start; key_held=1.
REQ-034 Glitch key 0xA for 1 frame, then release -> no key_valid; FSM returns to IDLE.
REQ-035 Press 0x3 then 0xC with key_ready=0 -> key_code stays 0x3, key_overrun=1; raise key_ready -> valid drops, overrun stays 1.
REQ-036 Hold 0x7, bounce open for 1 frame -> no second emit; open for 2 frames -> IDLE; a new press emits again.
REQ-037 Keys 0x1 and 0x2 pressed together from IDLE -> no emit; assert reset mid-frame -> row_out=4'b1110 and all outputs cleared immediately.
REQ-038 With KEYPAD_REPEAT_EN, hold 0xF for 10 frames with key_ready=1 -> emits at frames 2, 5, 7, 9.
